fifo_wr_rd_arbiter: RTL and testbench

// - Shares one 32-deep FIFO between NUM_REQ write requesters and one reader.
// - Round-robin write arbitration with bounded bursts; alternates write and read phases.
// - Drives the FIFO's separate wr_en/rd_en.
// - Sits between producer blocks and the FIFO; the consumer reads FIFO data_out directly.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_rr_pick.sv | 30 +++
 rtl/fifo_wr_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_rd_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write/read arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WBURST,
    RD
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_BURST_MAX = 4;
  localparam int unsigned DEF_DEPTH     = 32;

  // Burst counter is sized for the largest legal BURST_MAX (15).
  localparam int unsigned BURST_CNT_W   = 4;

  // Width of an index into an n-entry vector; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_last+1,
// wrapping modulo NUM_REQ.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  // Scan requesters starting one past the last owner; first hit wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(rr_last) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_rd_arbiter.sv
// Shares one FIFO between NUM_REQ round-robin write requesters and a single
// reader, alternating bounded write and read bursts separated by an IDLE cycle.
// Optional occupancy counter on fifo_level when FIFO_ARB_LEVEL_EN is defined;
// otherwise fifo_level is tied to zero.
module fifo_wr_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_MAX = DEF_BURST_MAX,
  parameter int unsigned DEPTH     = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        rd_req,
  output logic                        rd_gnt,
  input  logic                        fifo_full,
  input  logic                        fifo_empty,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  output logic                        fifo_rd_en,
  output logic [$clog2(DEPTH):0]      fifo_level
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic [IDX_W-1:0]       rr_last, rr_last_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic                   rd_turn, rd_turn_nxt;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   wr_fire;
  logic                   rd_fire;
  logic                   burst_last;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_last (rr_last),
    .valid   (pick_valid),
    .winner  (pick_idx)
  );

  assign wr_fire    = (state == WBURST) && req[owner] && !fifo_full;
  assign rd_fire    = (state == RD) && rd_req && !fifo_empty;
  assign burst_last = (burst_cnt == BURST_CNT_W'(BURST_MAX - 1));

  // State and arbitration bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_last   <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      rd_turn   <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_last   <= rr_last_nxt;
      burst_cnt <= burst_cnt_nxt;
      rd_turn   <= rd_turn_nxt;
    end
  end

  // Phase selection and burst termination.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_last_nxt   = rr_last;
    burst_cnt_nxt = burst_cnt;
    rd_turn_nxt   = rd_turn;
    case (state)
      IDLE: begin
        if (rd_req && !fifo_empty && (rd_turn || (req == '0))) begin
          state_nxt     = RD;
          burst_cnt_nxt = '0;
        end else if (pick_valid && !fifo_full) begin
          state_nxt     = WBURST;
          owner_nxt     = pick_idx;
          burst_cnt_nxt = '0;
        end
      end
      WBURST: begin
        if (wr_fire) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        if (!req[owner] || fifo_full || (wr_fire && burst_last)) begin
          state_nxt   = IDLE;
          rr_last_nxt = owner;
          rd_turn_nxt = 1'b1;
        end
      end
      RD: begin
        if (rd_fire) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        if (!rd_req || fifo_empty || (rd_fire && burst_last)) begin
          state_nxt   = IDLE;
          rd_turn_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grants and FIFO strobes; write data is zero outside a write phase.
  always_comb begin
    gnt          = '0;
    gnt[owner]   = wr_fire;
    fifo_wr_en   = wr_fire;
    rd_gnt       = rd_fire;
    fifo_rd_en   = rd_fire;
    fifo_wr_data = '0;
    if (state == WBURST) begin
      fifo_wr_data = req_data[owner*DATA_W +: DATA_W];
    end
  end

`ifdef FIFO_ARB_LEVEL_EN
  logic [LVL_W-1:0] level;

  // Occupancy tracking from our own strobes, saturating at 0 and DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (wr_fire && !rd_fire && (level != LVL_W'(DEPTH))) begin
      level <= level + 1'b1;
    end else if (rd_fire && !wr_fire && (level != '0)) begin
      level <= level - 1'b1;
    end
  end

  assign fifo_level = level;
`else
  assign fifo_level = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_rd_arbiter.sv
// Directed bench for fifo_wr_rd_arbiter (NUM_REQ=4, DATA_W=8, BURST_MAX=4).
module tb_fifo_wr_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rd_req;
  logic        rd_gnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_rd_en;
  logic [5:0]  fifo_level;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_wr_rd_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .BURST_MAX (4),
    .DEPTH     (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .rd_req       (rd_req),
    .rd_gnt       (rd_gnt),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_level   (fifo_level)
  );

  // Hold reset for two edges, release 1ns after a rising edge: caller is then in cycle 1.
  task automatic apply_reset();
    rst        = 1'b1;
    req        = 4'b0000;
    rd_req     = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    req_data   = 32'hA3A2A1A0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req        = 4'hF;
    rd_req     = 1'b1;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;
    req_data   = 32'hD3C2B1A0;
    @(negedge clk);
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt);
    else n_pass++;
    n_total++;
    if ({rd_gnt, fifo_wr_en, fifo_rd_en} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {rd_gnt, fifo_wr_en, fifo_rd_en});
    else n_pass++;
    n_total++;
    if (fifo_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data);
    else n_pass++;
    n_total++;
    if (fifo_level !== 6'd0) $display("FAIL reset_level: got %0d want 0", fifo_level);
    else n_pass++;
    apply_reset();
    @(negedge clk);
    n_total++;
    if ({gnt, rd_gnt, fifo_wr_en, fifo_rd_en} !== 7'b0)
      $display("FAIL post_reset_idle: got %b want 0000000", {gnt, rd_gnt, fifo_wr_en, fifo_rd_en});
    else n_pass++;
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_wr;
    logic [3:0] eg;
    exp_wr = 8'b1011_1100;
    apply_reset();
    req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      eg = exp_wr[c] ? 4'b0001 : 4'b0000;
      n_total++;
      if (gnt !== eg || fifo_wr_en !== exp_wr[c])
        $display("FAIL single_burst cycle %0d: gnt=%b wr_en=%b want gnt=%b wr_en=%b",
                 c, gnt, fifo_wr_en, eg, exp_wr[c]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [7:0] ed;
    int owner;
    apply_reset();
    req      = 4'hF;
    req_data = 32'hA3A2A1A0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if ((c - 1) % 5 == 0) begin
        eg = 4'b0000;
        n_total++;
        if (gnt !== eg || fifo_wr_en !== 1'b0)
          $display("FAIL rr_idle cycle %0d: gnt=%b wr_en=%b want gnt=0000 wr_en=0", c, gnt, fifo_wr_en);
        else n_pass++;
      end else begin
        owner = ((c - 2) / 5) % 4;
        eg    = 4'(1 << owner);
        ed    = 8'(8'hA0 + owner);
        n_total++;
        if (gnt !== eg || fifo_wr_data !== ed)
          $display("FAIL rr_grant cycle %0d: gnt=%b data=%h want gnt=%b data=%h",
                   c, gnt, fifo_wr_data, eg, ed);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_fifo_full();
    logic [9:0] exp_wr;
    logic [3:0] eg;
    exp_wr = 10'b10_0000_1100;
    apply_reset();
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      fifo_full = (c >= 4 && c <= 7);
      @(negedge clk);
      eg = exp_wr[c] ? 4'b0001 : 4'b0000;
      n_total++;
      if (gnt !== eg || fifo_wr_en !== exp_wr[c])
        $display("FAIL fifo_full cycle %0d: gnt=%b wr_en=%b want gnt=%b wr_en=%b",
                 c, gnt, fifo_wr_en, eg, exp_wr[c]);
      else n_pass++;
      next_cycle();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_alternation();
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
    logic [3:0]  eg;
    exp_wr = 16'b1111_0000_0011_1100;
    exp_rd = 16'b0000_0111_1000_0000;
    apply_reset();
    req        = 4'b0010;
    rd_req     = 1'b1;
    fifo_empty = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      eg = exp_wr[c] ? 4'b0010 : 4'b0000;
      n_total++;
      if (gnt !== eg || rd_gnt !== exp_rd[c] || fifo_rd_en !== exp_rd[c])
        $display("FAIL alternation cycle %0d: gnt=%b rd_gnt=%b rd_en=%b want gnt=%b rd=%b",
                 c, gnt, rd_gnt, fifo_rd_en, eg, exp_rd[c]);
      else n_pass++;
      n_total++;
      if ((fifo_wr_en & fifo_rd_en) !== 1'b0)
        $display("FAIL wr_rd_exclusive cycle %0d: wr_en=%b rd_en=%b want not both", c, fifo_wr_en, fifo_rd_en);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_read_empty();
    logic [10:0] exp_wr;
    logic [10:0] exp_rd;
    int          lv [1:10];
    int          el;
    exp_wr = 11'b000_0000_1100;
    exp_rd = 11'b000_1100_0000;
    lv     = '{0, 0, 1, 2, 2, 2, 1, 0, 0, 0};
    apply_reset();
    for (int c = 1; c <= 10; c++) begin
      req        = (c <= 3) ? 4'b0001 : 4'b0000;
      rd_req     = (c >= 5);
      fifo_empty = !(c >= 5 && c <= 7);
      @(negedge clk);
      n_total++;
      if (fifo_wr_en !== exp_wr[c] || rd_gnt !== exp_rd[c])
        $display("FAIL read_empty cycle %0d: wr_en=%b rd_gnt=%b want wr_en=%b rd_gnt=%b",
                 c, fifo_wr_en, rd_gnt, exp_wr[c], exp_rd[c]);
      else n_pass++;
`ifdef FIFO_ARB_LEVEL_EN
      el = lv[c];
`else
      el = 0;
`endif
      n_total++;
      if (fifo_level !== 6'(el))
        $display("FAIL level cycle %0d: got %0d want %0d", c, fifo_level, el);
      else n_pass++;
      next_cycle();
    end
    rd_req     = 1'b0;
    fifo_empty = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] exp_wr;
    logic [3:0] eg;
    exp_wr = 7'b011_1100;
    apply_reset();
    req = 4'b0010;
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL mid_burst_pre: gnt=%b want 0010", gnt);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({gnt, fifo_wr_en, fifo_wr_data} !== 13'b0)
      $display("FAIL mid_burst_async_reset: gnt=%b wr_en=%b data=%h want all 0",
               gnt, fifo_wr_en, fifo_wr_data);
    else n_pass++;
    req = 4'b0011;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      eg = exp_wr[c] ? 4'b0001 : 4'b0000;
      n_total++;
      if (gnt !== eg || (exp_wr[c] && fifo_wr_data !== 8'hA0))
        $display("FAIL after_reset cycle %0d: gnt=%b data=%h want gnt=%b data=a0",
                 c, gnt, fifo_wr_data, eg);
      else n_pass++;
      next_cycle();
    end
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    rd_req     = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_fifo_full();
    test_alternation();
    test_read_empty();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
